// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matmul feeders: default operand geometry and loader states.
package systolic_pkg;
  localparam int BITS_AB_DEF = 8;
  localparam int DIM_DEF     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RUN,
    DONE
  } ld_state_t;
endpackage

// File: rtl/row_packer.sv
// Assembles WPR bus words into one row of DIM signed elements; the row output already
// includes the word being accepted this cycle so the caller can capture a complete row at once.
module row_packer
  import systolic_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF,
  parameter int BUS_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      accept,
  input  logic [BUS_W-1:0]          in_data,
  output logic signed [BITS_AB-1:0] row [DIM-1:0],
  output logic                      row_complete
);
  localparam int EPW    = BUS_W / BITS_AB;
  localparam int WPR    = (DIM * BITS_AB) / BUS_W;
  localparam int WCNT_W = (WPR > 1) ? $clog2(WPR) : 1;

  logic [WCNT_W-1:0]         wcnt;
  logic signed [BITS_AB-1:0] asm_buf [DIM-1:0];

  assign row_complete = accept && (wcnt == WCNT_W'(WPR - 1));

  // Overlay the incoming word onto its slot of the buffered row
  always_comb begin
    for (int w = 0; w < WPR; w++) begin
      for (int e = 0; e < EPW; e++) begin
        row[w*EPW+e] = asm_buf[w*EPW+e];
        if (accept && (wcnt == WCNT_W'(w)))
          row[w*EPW+e] = $signed(in_data[e*BITS_AB +: BITS_AB]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wcnt <= '0;
    end else if (accept) begin
      wcnt <= row_complete ? '0 : wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++) asm_buf[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < DIM; i++) asm_buf[i] <= row[i];
    end
  end
endmodule

// File: rtl/mem_a_loader.sv
// A-side skew memory feeder: loads DIM rows from the host bus into the A memory,
// then holds the shift enable for the run window and pulses done.
module mem_a_loader
  import systolic_pkg::*;
#(
  parameter int BITS_AB    = BITS_AB_DEF,
  parameter int DIM        = DIM_DEF,
  parameter int BUS_W      = 32,
  parameter int RUN_CYCLES = 3 * DIM - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [BUS_W-1:0]              in_data,
  output logic                          in_ready,
  output logic signed [BITS_AB-1:0]     Ain [DIM-1:0],
  output logic [$clog2(DIM)-1:0]        Arow,
  output logic                          WrEn,
  output logic                          en,
  output logic                          busy,
  output logic                          done
);
  localparam int ROW_W = $clog2(DIM);
  localparam int RUN_W = $clog2(RUN_CYCLES + 1);

  if (((BUS_W % BITS_AB) != 0) || (((DIM * BITS_AB) % BUS_W) != 0)) begin : g_bad_cfg
    $error("mem_a_loader: BUS_W must hold whole elements and a row must be whole words");
  end

  ld_state_t                 state, state_nxt;
  logic [ROW_W-1:0]          rcnt;
  logic [RUN_W-1:0]          run_cnt;
  logic                      accept;
  logic                      load_go;
  logic                      last_row;
  logic                      run_last;
  logic                      row_complete;
  logic signed [BITS_AB-1:0] row [DIM-1:0];

  assign accept   = in_valid && in_ready;
  assign load_go  = (state == IDLE) && start;
  assign last_row = (rcnt == ROW_W'(DIM - 1));
  assign run_last = (run_cnt == RUN_W'(RUN_CYCLES - 1));

  row_packer #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .BUS_W   (BUS_W)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (load_go),
    .accept       (accept),
    .in_data      (in_data),
    .row          (row),
    .row_complete (row_complete)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (row_complete) state_nxt = WRITE;
      WRITE:   state_nxt = last_row ? RUN : LOAD;
      RUN:     if (run_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    WrEn     = 1'b0;
    en       = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      LOAD:    in_ready = 1'b1;
      WRITE:   WrEn = 1'b1;
      RUN:     en = 1'b1;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt    <= '0;
      run_cnt <= '0;
    end else begin
      if (load_go)
        rcnt <= '0;
      else if ((state == WRITE) && !last_row)
        rcnt <= rcnt + 1'b1;
      run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;
    end
  end

  // Row is captured on its final word so the write cycle presents it without extra delay
  always_ff @(posedge clk) begin
    if (rst) begin
      Arow <= '0;
      for (int i = 0; i < DIM; i++) Ain[i] <= '0;
    end else if (row_complete) begin
      Arow <= rcnt;
      for (int i = 0; i < DIM; i++) Ain[i] <= row[i];
    end
  end
endmodule
